// File: rtl/text_buf_ctrl_pkg.sv
// Shared types and constants for the on-screen text buffer controller.
package text_pkg;

  localparam int CHAR_ADDR_W = 8;
  localparam int CHAR_CODE_W = 8;
  localparam int NUM_CELLS   = 256;
  localparam logic [CHAR_CODE_W-1:0] BLANK_CHAR_DEF = 8'h20;

  typedef logic [CHAR_ADDR_W-1:0] char_addr_t;
  typedef logic [CHAR_CODE_W-1:0] char_code_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_WAIT = 2'd1,
    CLEAR    = 2'd2
  } tbc_state_t;

  // Round-robin grant for two requesters: a lone valid requester always wins,
  // on contention the pointer picks the winner. Bit N is the grant for requester N.
  function automatic logic [1:0] rr_grant(input logic v0, input logic v1, input logic rr);
    logic [1:0] g;
    g[0] = v0 & (~v1 | ~rr);
    g[1] = v1 & (~v0 | rr);
    return g;
  endfunction

endpackage

// File: rtl/text_buf_ctrl_if.sv
// Bus bundle between the text buffer controller and its users
// (timing chain, overlay read port, two writers, clear sequencer).
interface text_buf_if;
  import text_pkg::*;

  logic       vblnk_in;
  char_addr_t char_xy;
  char_code_t char_code;
  logic       req0_valid;
  char_addr_t req0_addr;
  char_code_t req0_data;
  logic       req0_ready;
  logic       req1_valid;
  char_addr_t req1_addr;
  char_code_t req1_data;
  logic       req1_ready;
  logic       clr_start;
  logic       clr_busy;

  modport master (
    output vblnk_in, char_xy,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output clr_start,
    input  char_code, req0_ready, req1_ready, clr_busy
  );

  modport slave (
    input  vblnk_in, char_xy,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  clr_start,
    output char_code, req0_ready, req1_ready, clr_busy
  );

endinterface

// File: rtl/text_buf_ctrl_char_ram.sv
// 256x8 character RAM: one synchronous write port, one registered read port.
// A read colliding with a write to the same cell returns the previous contents.
module char_ram
  import text_pkg::*;
#(
  parameter int DEPTH = NUM_CELLS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  char_addr_t wr_addr,
  input  char_code_t wr_data,
  input  char_addr_t rd_addr,
  output char_code_t rd_data
);

  char_code_t mem [DEPTH];

  // Array write; the array itself is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; non-blocking semantics give old data on a same-cell write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/text_buf_ctrl.sv
// Text buffer controller: owns the character RAM, arbitrates two writers
// round-robin, and sequences a full-screen clear, all writes confined to vblank.
module text_buf_ctrl
  import text_pkg::*;
#(
  parameter char_code_t BLANK_CHAR = BLANK_CHAR_DEF,
  parameter int         NUM_CELLS  = text_pkg::NUM_CELLS
) (
  input logic      clk,
  input logic      rst,
  text_buf_if.slave bus
);

  tbc_state_t state;
  tbc_state_t next_state;
  logic       rr_ptr;
  char_addr_t clr_cnt;
  logic       clr_busy;

  logic [1:0] grant;
  logic       ready0;
  logic       ready1;
  logic       acc0;
  logic       acc1;
  logic       we;
  char_addr_t wr_addr;
  char_code_t wr_data;

  assign grant = rr_grant(bus.req0_valid, bus.req1_valid, rr_ptr);
  assign acc0  = ready0 & bus.req0_valid;
  assign acc1  = ready1 & bus.req1_valid;

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.clr_busy   = clr_busy;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: clear waits for vblank, then walks all 256 cells.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.clr_start) begin
          next_state = CLR_WAIT;
        end else begin
          next_state = IDLE;
        end
      end
      CLR_WAIT: begin
        if (bus.vblnk_in) begin
          next_state = CLEAR;
        end else begin
          next_state = CLR_WAIT;
        end
      end
      CLEAR: begin
        if (bus.vblnk_in && (clr_cnt == 8'hFF)) begin
          next_state = IDLE;
        end else begin
          next_state = CLEAR;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic: readies and the write-port mux (clear beats requesters).
  always_comb begin
    ready0  = 1'b0;
    ready1  = 1'b0;
    we      = 1'b0;
    wr_addr = 8'h00;
    wr_data = 8'h00;
    case (state)
      IDLE: begin
        if (bus.vblnk_in && !bus.clr_start && !rst) begin
          ready0 = grant[0];
          ready1 = grant[1];
        end else begin
          ready0 = 1'b0;
          ready1 = 1'b0;
        end
        if (acc0) begin
          we      = 1'b1;
          wr_addr = bus.req0_addr;
          wr_data = bus.req0_data;
        end else if (acc1) begin
          we      = 1'b1;
          wr_addr = bus.req1_addr;
          wr_data = bus.req1_data;
        end else begin
          we      = 1'b0;
        end
      end
      CLEAR: begin
        if (bus.vblnk_in) begin
          we      = 1'b1;
          wr_addr = clr_cnt;
          wr_data = BLANK_CHAR;
        end else begin
          we      = 1'b0;
        end
      end
      default: begin
        we = 1'b0;
      end
    endcase
  end

  // Round-robin pointer: after a grant, favour the other requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (acc0) begin
      rr_ptr <= 1'b1;
    end else if (acc1) begin
      rr_ptr <= 1'b0;
    end
  end

  // Clear counter: zeroed on entry to CLEAR, advances on each vblank write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= 8'h00;
    end else if ((state == CLR_WAIT) && bus.vblnk_in) begin
      clr_cnt <= 8'h00;
    end else if ((state == CLEAR) && bus.vblnk_in) begin
      clr_cnt <= clr_cnt + 8'd1;
    end
  end

  // Busy flag: registered view of "a clear is pending or running".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_busy <= 1'b0;
    end else begin
      clr_busy <= (next_state != IDLE);
    end
  end

  char_ram #(
    .DEPTH(NUM_CELLS)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (bus.char_xy),
    .rd_data (bus.char_code)
  );

endmodule

// File: tb/tb_text_buf_ctrl.sv
// Directed bench for text_buf_ctrl with a read-data scoreboard and a shadow RAM model.
module tb_text_buf_ctrl;
  import text_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  text_buf_if bus ();

  text_buf_ctrl #(.BLANK_CHAR(8'h20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  logic [7:0] model [256];
  logic [7:0] exp_q [$];
  logic       rr = 1'b0;
  int         idx;
  int         p0;
  int         p1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rdy(input string tag, input logic e0, input logic e1);
    #1;
    check({tag, "_ready0"}, {7'd0, bus.req0_ready}, {7'd0, e0});
    check({tag, "_ready1"}, {7'd0, bus.req1_ready}, {7'd0, e1});
  endtask

  // One clock; optionally issues a read whose expected data is queued now and checked after the edge.
  task automatic cyc(input logic rd, input logic [7:0] a);
    logic [7:0] e;
    if (rd) begin
      bus.char_xy = a;
      exp_q.push_back(model[a]);
    end
    @(posedge clk);
    #1;
    if (rd) begin
      e = exp_q.pop_front();
      check($sformatf("char_code@%h", a), bus.char_code, e);
    end
  endtask

  task automatic wr0(input logic [7:0] a, input logic [7:0] d);
    bus.vblnk_in   = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = a;
    bus.req0_data  = d;
    chk_rdy("wr0", 1'b1, 1'b0);
    cyc(1'b0, 8'h00);
    model[a] = d;
    rr = 1'b1;
    bus.req0_valid = 1'b0;
  endtask

  task automatic check_busy(input string tag, input logic e);
    check(tag, {7'd0, bus.clr_busy}, {7'd0, e});
  endtask

  // n vblank cycles in CLEAR, each blanking cell idx; busy must drop right after cell 255.
  task automatic clr_cycles(input int n);
    bus.vblnk_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 8'h00);
      model[idx] = 8'h20;
      idx++;
      check_busy("clr_busy_run", (idx < 256) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic start_clear(input logic vb);
    bus.vblnk_in  = vb;
    bus.clr_start = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 8'hEE;
    bus.req0_data  = 8'hEE;
    chk_rdy("clr_start", 1'b0, 1'b0);
    cyc(1'b0, 8'h00);
    bus.clr_start = 1'b0;
    check_busy("clr_busy_rise", 1'b1);
  endtask

  initial begin
    bus.vblnk_in   = 1'b1;
    bus.char_xy    = 8'h00;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 8'h23;
    bus.req0_data  = 8'h41;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = 8'h00;
    bus.req1_data  = 8'h00;
    bus.clr_start  = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_char_code", bus.char_code, 8'h00);
    check_busy("rst_clr_busy", 1'b0);
    chk_rdy("in_reset", 1'b0, 1'b0);

    // req0 single write accepted in the same cycle, read back one cycle later
    rst = 1'b0;
    chk_rdy("t1", 1'b1, 1'b0);
    cyc(1'b0, 8'h00);
    model[8'h23] = 8'h41;
    rr = 1'b1;
    bus.req0_valid = 1'b0;
    cyc(1'b1, 8'h23);

    // req1 held outside vblank, accepted in the first vblank cycle
    bus.vblnk_in   = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 8'h05;
    bus.req1_data  = 8'h7A;
    for (int i = 0; i < 3; i++) begin
      chk_rdy("t2_noblank", 1'b0, 1'b0);
      cyc(1'b0, 8'h00);
    end
    bus.vblnk_in = 1'b1;
    chk_rdy("t2_blank", 1'b0, 1'b1);
    cyc(1'b0, 8'h00);
    model[8'h05] = 8'h7A;
    rr = 1'b0;
    bus.req1_valid = 1'b0;
    cyc(1'b1, 8'h05);

    // Sustained contention: grants alternate 0,1,0,1
    p0 = 0;
    p1 = 0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req0_addr = 8'h30 + 8'(p0);
      bus.req0_data = 8'hA0 + 8'(p0);
      bus.req1_addr = 8'h40 + 8'(p1);
      bus.req1_data = 8'hB0 + 8'(p1);
      chk_rdy($sformatf("contend%0d", i), ~rr, rr);
      cyc(1'b0, 8'h00);
      if (!rr) begin
        model[8'h30 + 8'(p0)] = 8'hA0 + 8'(p0);
        p0++;
      end else begin
        model[8'h40 + 8'(p1)] = 8'hB0 + 8'(p1);
        p1++;
      end
      rr = ~rr;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    cyc(1'b1, 8'h30);
    cyc(1'b1, 8'h31);
    cyc(1'b1, 8'h40);
    cyc(1'b1, 8'h41);

    // Clear requested outside vblank, vblank raised 10 cycles later
    start_clear(1'b0);
    for (int i = 0; i < 10; i++) begin
      chk_rdy("clr_wait", 1'b0, 1'b0);
      cyc(1'b0, 8'h00);
      check_busy("clr_wait_busy", 1'b1);
    end
    bus.req0_valid = 1'b0;
    bus.vblnk_in = 1'b1;
    cyc(1'b0, 8'h00);
    check_busy("clr_enter", 1'b1);
    idx = 0;
    clr_cycles(256);
    for (int a = 0; a < 256; a++) cyc(1'b1, 8'(a));

    // Read/write collision returns old data, then new data
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 8'h60;
    bus.req0_data  = 8'h99;
    chk_rdy("collide", 1'b1, 1'b0);
    cyc(1'b1, 8'h60);
    model[8'h60] = 8'h99;
    rr = 1'b1;
    bus.req0_valid = 1'b0;
    cyc(1'b1, 8'h60);

    // Clear paused at clr_cnt=100 for 50 cycles
    wr0(8'd50, 8'h55);
    wr0(8'd150, 8'h96);
    wr0(8'd200, 8'hC8);
    start_clear(1'b1);
    cyc(1'b0, 8'h00);
    idx = 0;
    clr_cycles(100);
    bus.vblnk_in = 1'b0;
    for (int i = 0; i < 50; i++) begin
      chk_rdy("pause", 1'b0, 1'b0);
      case (i % 5)
        0:       cyc(1'b1, 8'd150);
        1:       cyc(1'b1, 8'd200);
        2:       cyc(1'b1, 8'd50);
        3:       cyc(1'b1, 8'd99);
        default: cyc(1'b1, 8'd100);
      endcase
      check_busy("pause_busy", 1'b1);
    end
    bus.req0_valid = 1'b0;
    clr_cycles(156);
    cyc(1'b1, 8'd150);
    cyc(1'b1, 8'd200);
    cyc(1'b1, 8'd255);

    // Async reset at clr_cnt=40 aborts the clear
    wr0(8'd10, 8'h11);
    wr0(8'd40, 8'h44);
    wr0(8'd41, 8'h45);
    wr0(8'd200, 8'hAB);
    cyc(1'b1, 8'd200);
    start_clear(1'b1);
    bus.req0_valid = 1'b0;
    cyc(1'b0, 8'h00);
    idx = 0;
    clr_cycles(40);
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 8'h80;
    bus.req0_data  = 8'h77;
    rst = 1'b1;
    #1;
    check_busy("abort_busy", 1'b0);
    check("abort_char_code", bus.char_code, 8'h00);
    chk_rdy("abort", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_rdy("post_rst", 1'b1, 1'b0);
    cyc(1'b0, 8'h00);
    model[8'h80] = 8'h77;
    bus.req0_valid = 1'b0;
    cyc(1'b1, 8'd10);
    cyc(1'b1, 8'd39);
    cyc(1'b1, 8'd40);
    cyc(1'b1, 8'd41);
    cyc(1'b1, 8'd200);
    cyc(1'b1, 8'h80);
    check_busy("post_rst_busy", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
